// File: rtl/i2s_pkg.sv
// i2s_pkg: types and constants shared by the I2S clock generator, receiver
// and transmitter.
//   i2s_rx_state_t : receiver word-alignment state
//   I2S_LEFT/RIGHT : ws / channel encoding
package i2s_pkg;

  typedef enum logic [1:0] {
    ALIGN,
    CAPTURE,
    DRAIN
  } i2s_rx_state_t;

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_receiver_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clk_in : destination clock
//   rst_in : synchronous active-low reset, both flops clear to 0
//   d      : asynchronous input
//   q      : synchronized output (two-cycle latency)
module sync_2ff (
  input  logic clk_in,
  input  logic rst_in,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: deserializes I2S mic data into parallel PCM samples.
//   clk_in        : system clock (rising edge)
//   rst_in        : synchronous active-low reset
//   sck, ws       : bit clock / word select, registered in clk_in domain
//   sd            : asynchronous serial data from the mic
//   sample_out    : last completed sample, MSB-first capture, no sign extension
//   channel_out   : channel of sample_out (0 left, 1 right)
//   valid_out     : one-cycle pulse when sample_out/channel_out update
//   frame_err_out : one-cycle pulse when a slot ends before SAMPLE_WIDTH bits
// Build option: I2S_RX_RIGHT_EN defined captures both channels; undefined is
// the left-only mono build (right slots drained, channel_out stays 0).
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH       = 24,
  parameter int unsigned OVER_SAMPLING_RATE = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    sck,
  input  logic                    ws,
  input  logic                    sd,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    channel_out,
  output logic                    valid_out,
  output logic                    frame_err_out
);

  localparam int unsigned SLOT_BITS = OVER_SAMPLING_RATE / 2;
  localparam int unsigned CNT_W     = $clog2(SLOT_BITS) + 1;

  // Configuration sanity: the word plus the one-bit I2S delay must fit a slot.
  if (SAMPLE_WIDTH < 8 || SAMPLE_WIDTH >= SLOT_BITS) begin : g_bad_cfg
    $error("i2s_receiver: SAMPLE_WIDTH must be in 8..OVER_SAMPLING_RATE/2-1");
  end

  logic                    sd_s;
  logic                    sck_q;
  logic                    ws_q;
  logic                    rise_c;
  logic                    boundary_c;
  logic                    slot_en_c;
  logic                    next_chan_c;
  logic                    chan;
  logic [CNT_W-1:0]        bit_cnt;
  logic [SAMPLE_WIDTH-2:0] shreg;
  i2s_rx_state_t           state;

  sync_2ff u_sd_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d      (sd),
    .q      (sd_s)
  );

  assign rise_c     = sck & ~sck_q;
  assign boundary_c = rise_c & (ws != ws_q);

  // Which slots are captured, and the channel they report.
`ifdef I2S_RX_RIGHT_EN
  assign slot_en_c   = 1'b1;
  assign next_chan_c = ws;
`else
  assign slot_en_c   = (ws == I2S_LEFT);
  assign next_chan_c = I2S_LEFT;
`endif

  // Edge detect, slot alignment and shift-in of the serial word.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sck_q         <= 1'b0;
      ws_q          <= 1'b0;
      state         <= ALIGN;
      chan          <= I2S_LEFT;
      bit_cnt       <= '0;
      shreg         <= '0;
      sample_out    <= '0;
      channel_out   <= I2S_LEFT;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
      sck_q         <= sck;
      if (rise_c) begin
        ws_q <= ws;
      end

      case (state)
        ALIGN, DRAIN: begin
          // The boundary rise carries the previous slot's LSB; MSB is next.
          if (boundary_c) begin
            bit_cnt <= '0;
            if (slot_en_c) begin
              chan  <= next_chan_c;
              state <= CAPTURE;
            end else begin
              state <= DRAIN;
            end
          end
        end

        CAPTURE: begin
          if (boundary_c) begin
            // Slot ended early: drop the partial word and realign.
            frame_err_out <= 1'b1;
            bit_cnt       <= '0;
            if (slot_en_c) begin
              chan  <= next_chan_c;
              state <= CAPTURE;
            end else begin
              state <= DRAIN;
            end
          end else if (rise_c) begin
            shreg   <= {shreg[SAMPLE_WIDTH-3:0], sd_s};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(SAMPLE_WIDTH - 1)) begin
              sample_out  <= {shreg, sd_s};
              channel_out <= chan;
              valid_out   <= 1'b1;
              state       <= DRAIN;
            end
          end
        end

        default: state <= ALIGN;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: drives sck/ws like the I2S clock generator and a mic model
// that shifts sd on sck falling edges; checks sample/valid/error events with
// exact cycle timing against a slot-level reference model.
module tb_i2s_receiver;

  localparam int SW  = 24;
  localparam int OSR = 64;
  localparam int H   = 5;   // sck half-period in clk_in cycles
`ifdef I2S_RX_RIGHT_EN
  localparam bit RIGHT_EN = 1'b1;
`else
  localparam bit RIGHT_EN = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          sck;
  logic          ws;
  logic          sd;
  logic [SW-1:0] sample_out;
  logic          channel_out;
  logic          valid_out;
  logic          frame_err_out;

  i2s_receiver #(
    .SAMPLE_WIDTH       (SW),
    .OVER_SAMPLING_RATE (OSR)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .sck           (sck),
    .ws            (ws),
    .sd            (sd),
    .sample_out    (sample_out),
    .channel_out   (channel_out),
    .valid_out     (valid_out),
    .frame_err_out (frame_err_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic          ch;
    int            len;
    logic [SW-1:0] word;
    int            rst_at;
    bit            v_st, e_st, v_mo, e_mo;
  } vec_t;

  typedef struct {
    bit            is_err;
    logic [SW-1:0] data;
    logic          ch;
    longint        cyc;
  } ev_t;

  ev_t    exp_q[$];
  ev_t    act_q[$];
  longint cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     overlap = 0;
  int     hold_viol = 0;
  bit     mon_en = 1'b0;
  bit     rst_edge = 1'b0;
  bit     pend_err = 1'b0;
  logic   last_ws = 1'b0;
  logic [SW-1:0] prev_sample = '0;

  always @(posedge clk_in) begin
    cyc      <= cyc + 1;
    rst_edge <= !rst_in;
  end

  // Output monitor: collects events and checks the per-cycle invariants.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (valid_out)     act_q.push_back('{1'b0, sample_out, channel_out, cyc});
      if (frame_err_out) act_q.push_back('{1'b1, '0, 1'b0, cyc});
      if (valid_out && frame_err_out) overlap++;
      if (!valid_out && !rst_edge && sample_out !== prev_sample) hold_viol++;
      prev_sample = sample_out;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " sample_out"},    32'(sample_out),    32'd0);
    check({tag, " channel_out"},   32'(channel_out),   32'd0);
    check({tag, " valid_out"},     32'(valid_out),     32'd0);
    check({tag, " frame_err_out"}, 32'(frame_err_out), 32'd0);
  endtask

  function automatic logic exp_ch(input logic ch);
    return RIGHT_EN ? ch : 1'b0;
  endfunction

  // Reference: a slot is captured iff it starts with a ws change and its
  // channel is enabled; it yields a sample if it has room for the delay bit
  // plus SW data bits, otherwise an error at the next slot start.
  function automatic void model_slot(input logic ch, input int len, output bit ev, output bit ee);
    bit boundary = (ch != last_ws);
    bit en       = (ch == 1'b0) || RIGHT_EN;
    ev      = boundary && en && (len >= SW + 1);
    ee      = boundary && en && (len <  SW + 1);
    last_ws = ch;
  endfunction

  // One slot of len sck periods; optional reset pulse during period rst_at.
  task automatic drive_slot(input logic ch, input int len, input logic [SW-1:0] w,
                            input int rst_at, input bit ev, input bit ee);
    longint rc;
    for (int p = 0; p < len; p++) begin
      @(negedge clk_in);
      sck = 1'b0;
      ws  = ch;
      sd  = (p >= 1 && p <= SW) ? w[SW-p] : 1'($urandom);
      for (int k = 1; k < H; k++) begin
        @(negedge clk_in);
        if (p == rst_at && k == 1) rst_in = 1'b0;
        if (p == rst_at && k == 2) begin
          check_zero("mid-slot reset");
          rst_in   = 1'b1;
          pend_err = 1'b0;
          last_ws  = 1'b0;
        end
      end
      @(negedge clk_in);
      sck = 1'b1;
      rc  = cyc;
      if (p == 0 && pend_err) begin
        exp_q.push_back('{1'b1, '0, 1'b0, rc + 1});
        pend_err = 1'b0;
      end
      if (p == SW && ev) exp_q.push_back('{1'b0, w, exp_ch(ch), rc + 1});
      for (int k = 1; k < H; k++) @(negedge clk_in);
    end
    if (ee) pend_err = 1'b1;
  endtask

  task automatic cmp_events(input string tag);
    ev_t e, a;
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      n_cmp++;
      if (a.is_err != e.is_err || a.cyc != e.cyc ||
          (!e.is_err && (a.data !== e.data || a.ch !== e.ch))) begin
        n_bad++;
        $display("FAIL %s event: got err=%0b data=%h ch=%0b cyc=%0d, want err=%0b data=%h ch=%0b cyc=%0d",
                 tag, a.is_err, a.data, a.ch, a.cyc, e.is_err, e.data, e.ch, e.cyc);
      end
    end
  endtask

  vec_t tbl[23];

  initial begin
    logic ch;
    int   len;
    bit   ev, ee;

    //           ch    len word         rst  v_st e_st v_mo e_mo
    tbl[0]  = '{1'b0, 32, 24'h0BAD00,  12, 0, 0, 0, 0}; // reset mid-left, no boundary yet
    tbl[1]  = '{1'b1, 32, 24'h800001,  -1, 1, 0, 0, 0};
    tbl[2]  = '{1'b0, 32, 24'h123456,  -1, 1, 0, 1, 0};
    tbl[3]  = '{1'b1, 32, 24'hFFFFFF,  -1, 1, 0, 0, 0};
    tbl[4]  = '{1'b0, 32, 24'h000000,  10, 0, 0, 0, 0}; // reset during bit 10
    tbl[5]  = '{1'b1, 32, 24'hA5A5A5,  -1, 1, 0, 0, 0};
    tbl[6]  = '{1'b0, 32, 24'h5A5A5A,  -1, 1, 0, 1, 0};
    tbl[7]  = '{1'b1, 11, 24'h111111,  -1, 0, 1, 0, 0}; // short right slot
    tbl[8]  = '{1'b0, 32, 24'h222222,  -1, 1, 0, 1, 0};
    tbl[9]  = '{1'b1, 32, 24'h333333,  -1, 1, 0, 0, 0};
    tbl[10] = '{1'b0, 11, 24'h444444,  -1, 0, 1, 0, 1}; // short left slot
    tbl[11] = '{1'b1, 32, 24'h555555,  -1, 1, 0, 0, 0};
    tbl[12] = '{1'b0, 32, 24'h010203,  -1, 1, 0, 1, 0}; // four full frames
    tbl[13] = '{1'b1, 32, 24'hFEDCBA,  -1, 1, 0, 0, 0};
    tbl[14] = '{1'b0, 32, 24'h7F0080,  -1, 1, 0, 1, 0};
    tbl[15] = '{1'b1, 32, 24'h800000,  -1, 1, 0, 0, 0};
    tbl[16] = '{1'b0, 32, 24'h00FFFF,  -1, 1, 0, 1, 0};
    tbl[17] = '{1'b1, 32, 24'hC3C3C3,  -1, 1, 0, 0, 0};
    tbl[18] = '{1'b0, 32, 24'h9ABCDE,  -1, 1, 0, 1, 0};
    tbl[19] = '{1'b1, 32, 24'h000001,  -1, 1, 0, 0, 0};
    tbl[20] = '{1'b0, 25, 24'h7FFFFF,  -1, 1, 0, 1, 0}; // just long enough
    tbl[21] = '{1'b1, 24, 24'h0F0F0F,  -1, 0, 1, 0, 0}; // one bit short
    tbl[22] = '{1'b0, 32, 24'h00F00F,  -1, 1, 0, 1, 0};

    rst_in = 1'b0;
    sck    = 1'b0;
    ws     = 1'b0;
    sd     = 1'b0;
    repeat (3) @(negedge clk_in);
    check_zero("reset");
    rst_in = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive_slot(tbl[i].ch, tbl[i].len, tbl[i].word, tbl[i].rst_at,
                 RIGHT_EN ? tbl[i].v_st : tbl[i].v_mo,
                 RIGHT_EN ? tbl[i].e_st : tbl[i].e_mo);
      if (tbl[i].rst_at >= 0) last_ws = 1'b0;
      else last_ws = tbl[i].ch;
      cmp_events($sformatf("slot%0d", i));
    end

    ch = tbl[22].ch;
    for (int i = 0; i < 40; i++) begin
      ch  = ~ch;
      len = ($urandom_range(0, 3) == 0 && i != 39) ? int'($urandom_range(1, 31)) : 32;
      model_slot(ch, len, ev, ee);
      drive_slot(ch, len, 24'($urandom), -1, ev, ee);
      cmp_events($sformatf("rand%0d", i));
    end

    repeat (20) @(negedge clk_in);
    cmp_events("tail");
    check("missing events", 32'(exp_q.size()), 32'd0);
    check("extra events",   32'(act_q.size()), 32'd0);
    check("valid/err overlap cycles", 32'(overlap), 32'd0);
    check("sample hold violations", 32'(hold_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
